// File: rtl/input_sync_debounce_pkg.sv
// Shared defaults and sizing helpers for the input synchronizer/debouncer.
package input_sync_debounce_pkg;

   localparam int CHANNELS_DEF = 4;
   localparam int STAGES_DEF   = 2;
   localparam int DEBOUNCE_DEF = 1000;

   function automatic int cnt_width(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/input_sync_debounce_channel.sv
// One channel: synchronizer chain, saturating stability counter,
// debounced level and registered edge pulses.
module debounce_channel
   import input_sync_debounce_pkg::*;
#(
   parameter int STAGES          = STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
   parameter bit INIT            = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int W = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);

   logic [STAGES-1:0] sync;
   logic [W-1:0]      cnt;
   logic              synced;

   assign synced = sync[STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= {STAGES{INIT}};
      end else begin
         sync <= {sync[STAGES-2:0], din};
      end
   end

   // Level flips only after synced has disagreed for DEBOUNCE_CYCLES edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         level <= INIT;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (synced == level) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            cnt   <= '0;
            level <= ~level;
            rise  <= ~level;
            fall  <= level;
         end else begin
            cnt <= cnt + W'(1);
         end
      end
   end

endmodule

// File: rtl/input_sync_debounce.sv
// Top: reset synchronizer plus CHANNELS independent debounce channels.
module input_sync_debounce
   import input_sync_debounce_pkg::*;
#(
   parameter int                    CHANNELS        = CHANNELS_DEF,
   parameter int                    STAGES          = STAGES_DEF,
   parameter int                    DEBOUNCE_CYCLES = DEBOUNCE_DEF,
   parameter logic [CHANNELS-1:0]   INIT_LEVEL      = '0
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [CHANNELS-1:0] async_in,
   output logic                rst_syncn,
   output logic [CHANNELS-1:0] level,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall
);

   logic [STAGES-1:0] rs;

   // Asserts immediately, releases after STAGES clean edges.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rs <= '0;
      end else begin
         rs <= {rs[STAGES-2:0], 1'b1};
      end
   end

   assign rst_syncn = rs[STAGES-1];

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      debounce_channel #(
         .STAGES          (STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .INIT            (INIT_LEVEL[i])
      ) u_ch (
         .clk   (clk),
         .rst_n (rst_syncn),
         .din   (async_in[i]),
         .level (level[i]),
         .rise  (rise[i]),
         .fall  (fall[i])
      );
   end

endmodule

// File: tb/tb_input_sync_debounce.sv
// Directed and randomized checks of input_sync_debounce against a
// window-based reference model (4 channels, 2 stages, 4 debounce cycles).
module tb_input_sync_debounce;

   localparam int CH  = 4;
   localparam int STG = 2;
   localparam int DEB = 4;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [CH-1:0] async_in = '0;
   logic          rst_syncn;
   logic [CH-1:0] level, rise, fall;

   input_sync_debounce #(
      .CHANNELS        (CH),
      .STAGES          (STG),
      .DEBOUNCE_CYCLES (DEB),
      .INIT_LEVEL      ('0)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .async_in  (async_in),
      .rst_syncn (rst_syncn),
      .level     (level),
      .rise      (rise),
      .fall      (fall)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state
   logic [CH-1:0] hist[$];
   int            e_rel = 0;
   logic [CH-1:0] m_level = '0;
   logic [CH-1:0] m_rise = '0;
   logic [CH-1:0] m_fall = '0;
   logic          m_rsync = 1'b0;

   task automatic check(input string tag, input logic [3:0] obs,
                        input logic [3:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      check("rst_syncn", {3'b0, rst_syncn}, {3'b0, m_rsync});
      check("level", level, m_level);
      check("rise", rise, m_rise);
      check("fall", fall, m_fall);
   endtask

   // Level flips when the last DEB synced samples all disagree with it;
   // synced before channel edge k is the input sampled at edge k-STG.
   task automatic model_edge();
      int k, idx;
      bit ok;
      m_rise = '0;
      m_fall = '0;
      if (!rstn) return;
      if (e_rel >= STG) begin
         hist.push_back(async_in);
         k = hist.size();
         for (int c = 0; c < CH; c++) begin
            ok = 1'b1;
            for (int j = 0; j < DEB; j++) begin
               idx = k - j - STG;
               if (idx < 1) ok = 1'b0;
               else if (hist[idx-1][c] == m_level[c]) ok = 1'b0;
            end
            if (ok) begin
               m_level[c] = ~m_level[c];
               m_rise[c]  = m_level[c];
               m_fall[c]  = ~m_level[c];
            end
         end
      end
      if (e_rel < STG) e_rel++;
      m_rsync = (e_rel >= STG);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic assert_reset();
      rstn = 1'b0;
      #1;
      hist.delete();
      e_rel   = 0;
      m_level = '0;
      m_rise  = '0;
      m_fall  = '0;
      m_rsync = 1'b0;
      check_model();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int first, pulses;
      int hold[CH];
      logic [CH-1:0] cur;

      // Reset and release
      assert_reset();
      ticks(3);
      check("rst_hold_level", level, 4'b0000);
      rstn = 1'b1;
      tick();
      check("rel_edge1", {3'b0, rst_syncn}, 4'b0000);
      tick();
      check("rel_edge2", {3'b0, rst_syncn}, 4'b0001);
      check("rel_rise", rise, 4'b0000);
      check("rel_fall", fall, 4'b0000);

      // Clean step on channel 0
      async_in = 4'b0001;
      for (int t = 1; t <= 5; t++) begin
         tick();
         check("step_wait", level, 4'b0000);
      end
      tick();
      check("step_level", level, 4'b0001);
      check("step_rise", rise, 4'b0001);
      tick();
      check("step_rise_end", rise, 4'b0000);

      // Three-cycle glitch on channel 1
      async_in = 4'b0011;
      ticks(3);
      async_in = 4'b0001;
      for (int t = 0; t < 10; t++) begin
         tick();
         check("glitch_level", level, 4'b0001);
         check("glitch_pulse", rise | fall, 4'b0000);
      end

      // Bounce on channel 2
      async_in = 4'b0101;
      ticks(2);
      async_in = 4'b0001;
      ticks(2);
      async_in = 4'b0101;
      first = 0;
      pulses = 0;
      for (int t = 1; t <= 12; t++) begin
         tick();
         if (rise[2]) begin
            pulses++;
            if (first == 0) first = t;
         end
      end
      check("bounce_pulses", 4'(pulses), 4'd1);
      check("bounce_latency", 4'(first), 4'd6);

      // Simultaneous transitions
      async_in = 4'b0000;
      ticks(10);
      check("simul_base", level, 4'b0000);
      async_in = 4'b1111;
      ticks(5);
      check("simul_pre", rise, 4'b0000);
      tick();
      check("simul_rise", rise, 4'b1111);
      check("simul_level", level, 4'b1111);
      async_in = 4'b0101;
      ticks(5);
      tick();
      check("simul_fall", fall, 4'b1010);
      check("simul_frise", rise, 4'b0000);
      check("simul_level2", level, 4'b0101);

      // Reset in the middle of a count on channel 3
      async_in = 4'b0000;
      ticks(10);
      async_in = 4'b1000;
      ticks(4);
      assert_reset();
      check("midrst_level", level, 4'b0000);
      check("midrst_pulse", rise | fall, 4'b0000);
      ticks(2);
      rstn = 1'b1;
      ticks(2);
      check("midrst_sync", {3'b0, rst_syncn}, 4'b0001);
      for (int t = 1; t <= 5; t++) begin
         tick();
         check("midrst_wait", level, 4'b0000);
      end
      tick();
      check("midrst_level2", level, 4'b1000);
      check("midrst_rise", rise, 4'b1000);

      // Randomized phase with occasional resets
      cur = async_in;
      for (int c = 0; c < CH; c++) hold[c] = 0;
      for (int t = 0; t < 3000; t++) begin
         for (int c = 0; c < CH; c++) begin
            if (hold[c] == 0) begin
               cur[c]  = 1'($urandom_range(0, 1));
               hold[c] = int'($urandom_range(1, 8));
            end
            hold[c]--;
         end
         async_in = cur;
         if ($urandom_range(0, 299) == 0) begin
            assert_reset();
            ticks(int'($urandom_range(1, 3)));
            rstn = 1'b1;
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
